// File: rtl/gp_chain_pkg.sv
// Shared types and constants for the sequential generate/propagate carry-chain scheduler.
package gp_chain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GP_CHAIN_N_DEFAULT = 5;
    localparam int OPS_CNT_W          = 16;

endpackage

// File: rtl/gp_chain_sched_gp_cell.sv
// Single generate/propagate AND-OR cell: y = g | (p & c).
module gp_cell (
    input  logic g,
    input  logic p,
    input  logic c,
    output logic y
);

    assign y = g | (p & c);

endmodule

// File: rtl/gp_chain_sched.sv
// Time-multiplexed carry chain: one gp_cell evaluates stage idx per clock.
// Optional completed-operation counter on ops_cnt when GP_CHAIN_PERF_EN is defined.
module gp_chain_sched
    import gp_chain_pkg::*;
#(
    parameter int N = GP_CHAIN_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         c_in,
    input  logic [N-1:0] g,
    input  logic [N-1:0] p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] carry
`ifdef GP_CHAIN_PERF_EN
    ,
    output logic [OPS_CNT_W-1:0] ops_cnt
`endif
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_reg;
    state_t             state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               c_in_q;
    logic [N-1:0]       g_q;
    logic [N-1:0]       p_q;
    logic [N-1:0]       carry_reg;

    logic [N-1:0]       stage_sel;
    logic [N-1:0]       prev_vec;
    logic               g_bit;
    logic               p_bit;
    logic               prev_bit;
    logic               cell_y;
    logic               last_stage;
    logic               handoff;

    // One-hot decode of idx drives every per-stage mux, so no variable indexing is needed.
    for (genvar gi = 0; gi < N; gi++) begin : g_sel
        assign stage_sel[gi] = (idx_reg == IDX_W'(gi));
    end

    assign prev_vec   = {carry_reg[N-2:0], c_in_q};
    assign g_bit      = |(g_q & stage_sel);
    assign p_bit      = |(p_q & stage_sel);
    assign prev_bit   = |(prev_vec & stage_sel);
    assign last_stage = (idx_reg == IDX_W'(N - 1));
    assign handoff    = (state_reg == DONE) && out_ready;

    gp_cell u_cell (
        .g (g_bit),
        .p (p_bit),
        .c (prev_bit),
        .y (cell_y)
    );

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_stage) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            c_in_q    <= 1'b0;
            g_q       <= '0;
            p_q       <= '0;
            carry_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        c_in_q    <= c_in;
                        g_q       <= g;
                        p_q       <= p;
                        carry_reg <= '0;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    carry_reg <= (carry_reg & ~stage_sel) | ({N{cell_y}} & stage_sel);
                    if (!last_stage) idx_reg <= idx_reg + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign carry = carry_reg;

`ifdef GP_CHAIN_PERF_EN
    logic [OPS_CNT_W-1:0] ops_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_cnt_reg <= '0;
        end else if (handoff && (ops_cnt_reg != {OPS_CNT_W{1'b1}})) begin
            ops_cnt_reg <= ops_cnt_reg + OPS_CNT_W'(1);
        end
    end

    assign ops_cnt = ops_cnt_reg;
`else
    logic unused_handoff;
    assign unused_handoff = handoff;
`endif

endmodule
